// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder slice.
package data_mem_responder_pkg;

  localparam int WORD_W     = 32;
  localparam int ADDR_SHIFT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/data_mem_array.sv
// Single-port DEPTH x 32 RAM with synchronous write and synchronous read.
// The read register only updates on a read, so it holds the last read word.
module data_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rdata_d;
  logic [WORD_W-1:0] rdata_q;

  // Next read-register value: new word on a read, otherwise hold.
  always_comb begin
    rdata_d = re ? mem[addr] : rdata_q;
  end

  // Storage and read register.
  // NOTE: the array and its read register have no reset; resetting a RAM
  // prevents block-RAM inference and the contents must survive rst_n anyway.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side end of the CPU load/store port: accepts one request, waits
// WAIT_CYCLES, commits the access to data_mem_array, then strobes a
// one-cycle response.
// Optional feature macro: DATA_MEM_ALIGN_CHECK_EN (misaligned address -> error).
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        busy_q, busy_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic        rd_ok_q, rd_ok_d;

  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        accept;
  logic        commit;
  logic        cur_write;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        acc_err;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;

  assign accept = (state_q == IDLE) && req_valid && req_ready_q;

  // The access commits at the last WAIT edge, or at acceptance when there
  // are no wait states; in the latter case the live request is used.
  always_comb begin
    commit    = ((state_q == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                ((state_q == WAIT) && (cnt_q <= 4'd1));
    cur_write = (state_q == IDLE) ? req_write : write_q;
    cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  end

  // Range check on the word index, plus the optional alignment check.
`ifdef DATA_MEM_ALIGN_CHECK_EN
  always_comb begin
    acc_err = (cur_addr[31:ADDR_SHIFT] >= 30'(DEPTH)) ||
              (cur_addr[ADDR_SHIFT-1:0] != '0);
  end
`else
  logic unused_byte_offset;
  assign unused_byte_offset = ^cur_addr[ADDR_SHIFT-1:0];

  always_comb begin
    acc_err = (cur_addr[31:ADDR_SHIFT] >= 30'(DEPTH));
  end
`endif

  assign ram_we = commit && cur_write && !acc_err;
  assign ram_re = commit && !cur_write && !acc_err;

  data_mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (cur_addr[AW+ADDR_SHIFT-1:ADDR_SHIFT]),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  // Next-state, counter, request latch and registered-output logic.
  // NOTE: every variable gets a default at the top so no path can leave it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d  = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    resp_valid_d = (state_d == RESP);
    resp_err_d   = commit ? acc_err : resp_err_q;
    rd_ok_d      = commit ? ram_re  : rd_ok_q;
  end

  // FSM state, wait counter and response registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rd_ok_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rd_ok_q      <= rd_ok_d;
    end
  end

  // Latched request copy; pure datapath, only meaningful after acceptance.
  always_ff @(posedge clk) begin
    write_q <= write_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = rd_ok_q ? ram_rdata : 32'h0;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder: the memory-side end of the CPU's load/store port. It accepts one word-wide read or write request per handshake, inserts a configurable number of wait states, then returns a single-cycle response carrying read data and an error flag. It sits between the control unit's memory-access states and the word-addressed data RAM, so memory latency is decoupled from the control FSM.

## Interface

Parameters:
- DEPTH, 256, number of 32-bit words; the word index is req_addr[31:2].
- WAIT_CYCLES, 2, wait states between request acceptance and response; legal range 0–15.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_ready  output  1  responder can accept a request.
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  request rejected (range or alignment).
- busy  output  1  high whenever state ≠ IDLE.

## Operation

- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. A request is accepted when req_valid && req_ready. On acceptance, latch write/addr/wdata and load the wait counter with WAIT_CYCLES. Next state is WAIT, or RESP if WAIT_CYCLES=0.
- WAIT: the counter decrements each cycle. When it reaches 1, commit the access:
  - read the RAM into the response register, or write the RAM;
  - next state is RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready is 0 in WAIT and RESP.
- Error: word index ≥ DEPTH sets resp_err=1. In that case no write occurs and resp_rdata=0.
- For WAIT_CYCLES=0, the commit happens on the transition into RESP.
- RAM contents are not reset. Only FSM state, counter and outputs are reset.

## Timing

- Reset values: req_ready=0 while rst_n is low, then 1 in IDLE. resp_valid=0, resp_rdata=0, resp_err=0, busy=0. State is IDLE.
- Latency: resp_valid rises WAIT_CYCLES+1 cycles after the acceptance edge.
- Throughput: one request per WAIT_CYCLES+2 cycles. The earliest next acceptance is the cycle after RESP.
- resp_rdata and resp_err are valid only while resp_valid=1. They hold their value until the next commit.
- A store is visible to a load accepted any later cycle.
- req_* inputs are ignored outside IDLE. The latched copy is used, so the requester may change them after acceptance.
- Reset mid-operation aborts immediately and no response is issued. A write is lost if reset asserts before the commit edge; a committed write persists.
- A request held at req_valid=1 across RESP is accepted in the following IDLE cycle. This counts as a new request.

## Configuration

- Macro: DATA_MEM_ALIGN_CHECK_EN.
- Defined: req_addr[1:0] ≠ 0 sets resp_err=1 in addition to the range check. The store is suppressed and resp_rdata=0.
- Undefined: req_addr[1:0] is ignored and the access is word-aligned by truncation.

## Structure

- Shared package: the state enum (IDLE/WAIT/RESP), the word width constant (32) and the address-to-word shift (2).
- One sub-module, data_mem_array: a synchronous-read, synchronous-write DEPTH×32 RAM with a single port.
- FSM, counter, range/alignment checks and response registers live in the top.

## Test plan

- Reset, then store 0xDEADBEEF to 0x10, then load from 0x10. Required: the load response carries resp_rdata=0xDEADBEEF and resp_err=0. resp_valid rises exactly 3 cycles after each acceptance with WAIT_CYCLES=2.
- WAIT_CYCLES=0, back-to-back loads with req_valid held high. Required: resp_valid every 2nd cycle and req_ready toggles 1/0.
- Out-of-range store to 0x400 (DEPTH=256), then load 0x0. Required:
  - the store gets resp_err=1;
  - word 0 is unchanged;
  - the load gets resp_err=0.
- Misaligned load from 0x13 after storing 0x12345678 at 0x10:
  - with DATA_MEM_ALIGN_CHECK_EN, resp_err=1 and rdata=0;
  - without it, rdata=0x12345678.
- Reset asserted during WAIT of a store of 0xCAFEF00D to 0x20. Required:
  - outputs return to reset values asynchronously;
  - no resp_valid is issued;
  - a subsequent load of 0x20 returns the prior value.
- Change req_addr/req_wdata during WAIT. Required: the response and the RAM reflect the latched values only.
